// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with registered coordinate, active-region,
// sync and strobe outputs, plus a free-running frame counter.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       frame_active,
  output logic       h_sync,
  output logic       v_sync,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] frame_ctr
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [9:0] frame_ctr_q, frame_ctr_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       frame_active_q, frame_active_d;
  logic       h_sync_q, h_sync_d;
  logic       v_sync_q, v_sync_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       h_wrap, v_wrap;
  logic       h_act, v_act;

  always_comb begin
    h_wrap      = (h_cnt_q == H_LAST);
    v_wrap      = h_wrap && (v_cnt_q == V_LAST);
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    frame_ctr_d = frame_ctr_q;
    if (pix_en) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
      if (h_wrap) begin
        v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
      end
      if (v_wrap) begin
        frame_ctr_d = frame_ctr_q + 10'd1;
      end
    end
  end

  // Outputs decode the next-state counters so the registered outputs line up with h_cnt_q/v_cnt_q.
  always_comb begin
    h_act          = (h_cnt_d < H_ACT);
    v_act          = (v_cnt_d < V_ACT);
    x_d            = h_act ? h_cnt_d : '0;
    y_d            = v_act ? v_cnt_d[8:0] : '0;
    frame_active_d = h_act && v_act;
    h_sync_d       = ((h_cnt_d >= HS_BEG) && (h_cnt_d < HS_END)) ? H_POL : ~H_POL;
    v_sync_d       = ((v_cnt_d >= VS_BEG) && (v_cnt_d < VS_END)) ? V_POL : ~V_POL;
    line_start_d   = pix_en && h_wrap;
    frame_start_d  = pix_en && v_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      frame_ctr_q    <= '0;
      x_q            <= '0;
      y_q            <= '0;
      frame_active_q <= 1'b1;
      h_sync_q       <= ~H_POL;
      v_sync_q       <= ~V_POL;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      frame_ctr_q    <= frame_ctr_d;
      x_q            <= x_d;
      y_q            <= y_d;
      frame_active_q <= frame_active_d;
      h_sync_q       <= h_sync_d;
      v_sync_q       <= v_sync_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign x            = x_q;
  assign y            = y_q;
  assign frame_active = frame_active_q;
  assign h_sync       = h_sync_q;
  assign v_sync       = v_sync_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign frame_ctr    = frame_ctr_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a tiny-timing instance (7x5 raster)
// checked against hand-computed output snapshots through an expectation queue.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       fa;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [9:0] fc;
  } snap_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0;
  logic pix_en_a = 1'b0, pix_en_b = 1'b0;

  logic [9:0] x_a, x_b, fc_a, fc_b;
  logic [8:0] y_a, y_b;
  logic fa_a, hs_a, vs_a, ls_a, fs_a;
  logic fa_b, hs_b, vs_b, ls_b, fs_b;
  snap_t snap_a, snap_b;

  assign snap_a = {x_a, y_a, fa_a, hs_a, vs_a, ls_a, fs_a, fc_a};
  assign snap_b = {x_b, y_b, fa_b, hs_b, vs_b, ls_b, fs_b, fc_b};

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .pix_en(pix_en_a),
    .x(x_a), .y(y_a), .frame_active(fa_a), .h_sync(hs_a), .v_sync(vs_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_ctr(fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .pix_en(pix_en_b),
    .x(x_b), .y(y_b), .frame_active(fa_b), .h_sync(hs_b), .v_sync(vs_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_ctr(fc_b)
  );

  always #5 clk = ~clk;

  snap_t q_exp[$];
  string q_tag[$];
  bit    q_sel[$];
  int    n_pushed = 0;
  int    n_popped = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    e_cur = 0;

  function automatic snap_t S(input int xv, input int yv, input bit fa, input bit hs,
                              input bit vs, input bit ls, input bit fs, input int fc);
    return {10'(xv), 9'(yv), fa, hs, vs, ls, fs, 10'(fc)};
  endfunction

  task automatic push(input bit sel, input string tag, input snap_t exp);
    q_exp.push_back(exp);
    q_tag.push_back(tag);
    q_sel.push_back(sel);
    n_pushed++;
  endtask

  // Advance the selected instance to edge_n edges after its release; enabled every period-th edge.
  task automatic go_to(input bit sel, input int edge_n, input int period);
    while (e_cur < edge_n) begin
      if (sel) pix_en_b = ((e_cur % period) == 0);
      else     pix_en_a = ((e_cur % period) == 0);
      @(posedge clk);
      e_cur++;
      @(negedge clk);
    end
  endtask

  task automatic chk(input bit sel, input int edge_n, input int period, input string tag,
                     input snap_t exp);
    go_to(sel, edge_n, period);
    push(sel, tag, exp);
  endtask

  task automatic sync_reset(input bit sel);
    @(negedge clk);
    if (sel) rst_b = 1'b1; else rst_a = 1'b1;
    pix_en_a = 1'b0;
    pix_en_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (sel) rst_b = 1'b0; else rst_a = 1'b0;
    e_cur = 0;
  endtask

  // Monitor: compares every queued expectation against the instance it names.
  initial begin
    snap_t exp, act;
    string tag;
    bit    sel;
    forever begin
      wait (n_popped != n_pushed);
      exp = q_exp.pop_front();
      tag = q_tag.pop_front();
      sel = q_sel.pop_front();
      n_popped++;
      act = sel ? snap_b : snap_a;
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL %s: got x=%0d y=%0d fa=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, expected x=%0d y=%0d fa=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                 tag, act.x, act.y, act.fa, act.hs, act.vs, act.ls, act.fs, act.fc,
                 exp.x, exp.y, exp.fa, exp.hs, exp.vs, exp.ls, exp.fs, exp.fc);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach its end, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    snap_t rv;
    rv = S(0, 0, 1, 1, 1, 0, 0, 0);

    // Reset values before any clock edge, then with the clock running.
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    push(0, "rst_pre_clk_a", rv);
    push(1, "rst_pre_clk_b", rv);
    repeat (3) @(posedge clk);
    @(negedge clk);
    push(0, "rst_held_a", rv);
    push(1, "rst_held_b", rv);
    rst_a = 1'b0;
    e_cur = 0;

    // Horizontal timing, pix_en tied high.
    chk(0, 1,   1, "h_first",    S(1,   0, 1, 1, 1, 0, 0, 0));
    chk(0, 639, 1, "h_last_act", S(639, 0, 1, 1, 1, 0, 0, 0));
    chk(0, 640, 1, "h_blank",    S(0,   0, 0, 1, 1, 0, 0, 0));
    chk(0, 655, 1, "h_fp_end",   S(0,   0, 0, 1, 1, 0, 0, 0));
    chk(0, 656, 1, "hs_fall",    S(0,   0, 0, 0, 1, 0, 0, 0));
    chk(0, 751, 1, "hs_last",    S(0,   0, 0, 0, 1, 0, 0, 0));
    chk(0, 752, 1, "hs_rise",    S(0,   0, 0, 1, 1, 0, 0, 0));
    chk(0, 799, 1, "h_last",     S(0,   0, 0, 1, 1, 0, 0, 0));
    chk(0, 800, 1, "line1_ls",   S(0,   1, 1, 1, 1, 1, 0, 0));
    chk(0, 801, 1, "line1_px1",  S(1,   1, 1, 1, 1, 0, 0, 0));
    chk(0, 1100, 1, "pos300_1",  S(300, 1, 1, 1, 1, 0, 0, 0));

    // Sub-cycle reset pulse between edges, then restart from the origin.
    rst_a = 1'b1;
    #1;
    push(0, "midrst_async", rv);
    #1;
    rst_a = 1'b0;
    e_cur = 0;
    chk(0, 1, 1, "midrst_restart", S(1, 0, 1, 1, 1, 0, 0, 0));

    // Enable on every other clock: advances happen on odd edges only.
    sync_reset(0);
    chk(0, 1,    2, "en2_adv",     S(1, 0, 1, 1, 1, 0, 0, 0));
    chk(0, 2,    2, "en2_hold",    S(1, 0, 1, 1, 1, 0, 0, 0));
    chk(0, 1598, 2, "en2_h799",    S(0, 0, 0, 1, 1, 0, 0, 0));
    chk(0, 1599, 2, "en2_ls",      S(0, 1, 1, 1, 1, 1, 0, 0));
    chk(0, 1600, 2, "en2_ls_w1",   S(0, 1, 1, 1, 1, 0, 0, 0));
    chk(0, 1601, 2, "en2_px1",     S(1, 1, 1, 1, 1, 0, 0, 0));
    chk(0, 3199, 2, "en2_ls2",     S(0, 2, 1, 1, 1, 1, 0, 0));
    chk(0, 3200, 2, "en2_ls2_w1",  S(0, 2, 1, 1, 1, 0, 0, 0));
    pix_en_a = 1'b0;

    // Small raster: 7 clk per line, 5 lines per frame, 35 clk per frame.
    rst_b = 1'b0;
    e_cur = 0;
    chk(1, 7,  1, "b_line1",     S(0, 1, 1, 1, 1, 1, 0, 0));
    chk(1, 14, 1, "b_vblank",    S(0, 0, 0, 1, 1, 1, 0, 0));
    chk(1, 15, 1, "b_vblank_x",  S(1, 0, 0, 1, 1, 0, 0, 0));
    chk(1, 20, 1, "b_pre_vs",    S(0, 0, 0, 1, 1, 0, 0, 0));
    chk(1, 21, 1, "b_vs_fall",   S(0, 0, 0, 1, 0, 1, 0, 0));
    chk(1, 26, 1, "b_hs_in_vs",  S(0, 0, 0, 0, 0, 0, 0, 0));
    chk(1, 27, 1, "b_vs_last",   S(0, 0, 0, 1, 0, 0, 0, 0));
    chk(1, 28, 1, "b_vs_rise",   S(0, 0, 0, 1, 1, 1, 0, 0));
    chk(1, 34, 1, "b_frame_end", S(0, 0, 0, 1, 1, 0, 0, 0));
    chk(1, 35, 1, "b_fs1",       S(0, 0, 1, 1, 1, 1, 1, 1));
    chk(1, 36, 1, "b_fs1_w1",    S(1, 0, 1, 1, 1, 0, 0, 1));
    chk(1, 35 * 1023 - 1, 1, "b_pre_1023", S(0, 0, 0, 1, 1, 0, 0, 1022));
    chk(1, 35 * 1023,     1, "b_fc1023",   S(0, 0, 1, 1, 1, 1, 1, 1023));
    chk(1, 35 * 1024 - 1, 1, "b_pre_wrap", S(0, 0, 0, 1, 1, 0, 0, 1023));
    chk(1, 35 * 1024,     1, "b_fc_wrap",  S(0, 0, 1, 1, 1, 1, 1, 0));
    chk(1, 35 * 1024 + 1, 1, "b_after",    S(1, 0, 1, 1, 1, 0, 0, 0));
    pix_en_b = 1'b0;

    #10;
    if (n_popped != n_pushed) begin
      n_bad++;
      $display("FAIL drain: got %0d checked, expected %0d", n_popped, n_pushed);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the raster scan that drives the pixel pipeline. It produces the pixel coordinates, the active-region flag and the horizontal/vertical sync pulses consumed by the graphics engine and the VGA pins. It also provides line/frame strobes and a free-running frame counter for animation. It sits between the top-level clock/reset and `graphics_engine`.

## Interface

**Parameters**
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: horizontal sync width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `H_POL`, 0: asserted level of `h_sync` (0 = negative pulse)
- `V_POL`, 0: asserted level of `v_sync`

**Ports**
- `clk`  in  1  system clock; one clock cycle is one pixel slot when `pix_en` is tied high
- `rst`  in  1  asynchronous, active-high reset
- `pix_en`  in  1  pixel advance enable
- `x`  out  10  current pixel column
- `y`  out  9  current pixel row
- `frame_active`  out  1  high inside the visible region
- `h_sync`  out  1  horizontal sync, polarity set by `H_POL`
- `v_sync`  out  1  vertical sync, polarity set by `V_POL`
- `line_start`  out  1  one-`clk` strobe at the start of each line
- `frame_start`  out  1  one-`clk` strobe at the start of each frame
- `frame_ctr`  out  10  frame count, modulo 1024

## Operation

- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default)
- Counters: internal `h_cnt` (10 b) and `v_cnt` (10 b).
  - Both advance only in cycles where `pix_en`=1.
- Horizontal counter: `h_cnt` goes 0..H_TOTAL-1, then wraps to 0.
- Vertical counter: `v_cnt` increments on every `h_cnt` wrap.
  - `v_cnt` wraps to 0 after V_TOTAL-1.
  - On that wrap, `frame_ctr` increments, modulo 1024; 1023 -> 0.
- Every output is a register loaded from the next-state counter values, so outputs are cycle-aligned with the counters.
- `frame_active` = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- `x` = h_cnt when h_cnt < H_ACTIVE, else 0.
- `y` = v_cnt[8:0] when v_cnt < V_ACTIVE, else 0.
- `h_sync` = H_POL when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751), else ~H_POL.
- `v_sync` = V_POL when V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), else ~V_POL.
  - The pulse spans the full lines, including every h_cnt value of those lines.
- `line_start` is high for exactly one `clk` after a `pix_en` advance that moves `h_cnt` to 0.
- `frame_start` is high for exactly one `clk` when that same advance also moves `v_cnt` to 0.
  - `line_start` is high in that cycle too.
- While `pix_en`=0:
  - counters, `x`, `y`, `frame_active`, the syncs and `frame_ctr` hold their values;
  - the strobes are 0.

## Timing

- Reset values, applied asynchronously while `rst`=1:
  - h_cnt = v_cnt = 0, `x` = 0, `y` = 0
  - `frame_active` = 1
  - `h_sync` = ~H_POL, `v_sync` = ~V_POL
  - `line_start` = `frame_start` = 0, `frame_ctr` = 0
- Reset release: the first `pix_en`=1 edge moves the position to (1,0). No strobe is issued for the reset position.
- Reset mid-frame: all state returns to the reset values immediately, independent of `clk`.
- Latency: zero cycles between a counter value and its decoded outputs.
- Rates, with `pix_en` tied high:
  - line period = 800 clk
  - frame period = 420 000 clk
  - `h_sync` low for 96 clk
  - `v_sync` low for 1600 clk
- `pix_en` duty below 100% stretches every period by the enable ratio. Strobe width stays one `clk`.
- Simultaneous h and v wrap: `v_cnt`, `frame_ctr` and both strobes update on the same edge.

## Test plan

- **Reset values:** hold `rst`=1 with `clk` running -> x=0, y=0, frame_active=1, h_sync=1, v_sync=1, strobes=0, frame_ctr=0. Check this also before any `clk` edge.
- **Horizontal timing:** `pix_en`=1 from reset release ->
  - frame_active falls after 640 edges;
  - h_sync falls after 656 edges and rises after 752;
  - line_start pulses after 800 edges with x=0, y=1.
- **Vertical timing:** continue ->
  - frame_active stays 0 for all of lines 480..524;
  - v_sync low from edge 392 000 to edge 393 600;
  - frame_start and line_start pulse together at edge 420 000, with frame_ctr=1 and y=0.
- **Enable gating:** `pix_en` high every other `clk` ->
  - line period = 1600 clk;
  - strobes still exactly 1 clk wide;
  - outputs frozen during `pix_en`=0 cycles.
- **Mid-frame reset:** pulse `rst` for a sub-cycle width at position (300,200) -> outputs take the reset values immediately, and counting restarts from (0,0).
- **Frame counter wrap:** set V_ACTIVE=2, V_FP=V_SYNC=V_BP=1, H_ACTIVE=4, H_FP=H_SYNC=H_BP=1 and run 1024 frames -> frame_ctr 1023 -> 0 on the 1024th frame_start.
